// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: two-port OBI front end for a row of sky130_sram_2kbyte_1rw1r_32x512_8
// macros. Port D (read/write) drives macro port 0 and port I (read-only) drives macro port 1.
// Out-of-window accesses return an error response. A D write racing an I read of the same
// word is serialised by a one-bit fairness flag (prio_i).
// Optional build macro: SRAM_BANK_CTRL_OUT_REG_EN adds one register stage on every response
// output, so responses arrive 2 cycles after the grant instead of 1.
// Each bank below is a behavioural stand-in that has the macro's pin behaviour: active-low
// chip selects, active-low write enable, byte write mask, and a registered read port.
module sram_bank_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_BANKS   = 24,
  parameter int          BANK_ADDR_W = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  output logic        illegal_memory_o
);

  localparam int          BANK_BYTES_W = BANK_ADDR_W + 2;
  localparam int          BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  // END_ADDR is exclusive. It is 33 bits wide so that a window ending exactly at 4 GiB
  // does not wrap around to zero.
  localparam logic [32:0] END_ADDR     = {1'b0, BASE_ADDR} + (33'(NUM_BANKS) << BANK_BYTES_W);

  logic [31:0]            d_off, i_off;
  logic                   d_legal, i_legal;
  logic [BANK_W-1:0]      d_bank, i_bank;
  logic [BANK_ADDR_W-1:0] d_word, i_word;
  logic                   hazard, d_gnt, i_gnt, prio_i;
  logic [NUM_BANKS-1:0]   d_hit, i_hit, d_sel_q, i_sel_q;
  logic [NUM_BANKS*32-1:0] d_dout, i_dout;
  logic                   d_valid_q, d_err_q, i_valid_q, i_err_q, illegal_q;
  logic [31:0]            d_rd, i_rd;
  logic                   web0;
  logic [3:0]             wmask0;
  logic                   unused_off;

  assign d_off   = d_addr_i - BASE_ADDR;
  assign i_off   = i_addr_i - BASE_ADDR;
  assign d_legal = ({1'b0, d_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, d_addr_i} < END_ADDR);
  assign i_legal = ({1'b0, i_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, i_addr_i} < END_ADDR) && !i_we_i;
  assign d_bank  = d_off[BANK_BYTES_W +: BANK_W];
  assign i_bank  = i_off[BANK_BYTES_W +: BANK_W];
  assign d_word  = d_addr_i[BANK_ADDR_W+1:2];
  assign i_word  = i_addr_i[BANK_ADDR_W+1:2];
  assign unused_off = ^{d_off, i_off};

  // A D write and an I read of the same word in the same cycle are not defined for the
  // macro, so one of the two is held back for a cycle. prio_i decides which one.
  assign hazard = d_req_i & d_we_i & d_legal & i_req_i & i_legal &
                  (d_bank == i_bank) & (d_word == i_word);
  assign d_gnt  = ~rst_i & d_req_i & ~(hazard & prio_i);
  assign i_gnt  = ~rst_i & i_req_i & ~(hazard & ~prio_i);
  assign d_gnt_o = d_gnt;
  assign i_gnt_o = i_gnt;

  assign web0   = ~d_we_i;
  assign wmask0 = d_be_i;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [31:0] mem [2**BANK_ADDR_W];
      logic [31:0] dout0, dout1;
      logic        csb0, csb1;

      assign d_hit[b] = d_gnt & d_legal & (d_bank == BANK_W'(b));
      assign i_hit[b] = i_gnt & i_legal & (i_bank == BANK_W'(b));
      assign csb0 = ~d_hit[b];
      assign csb1 = ~i_hit[b];
      assign d_dout[b*32 +: 32] = dout0;
      assign i_dout[b*32 +: 32] = dout1;

      // Macro port 0: a byte-masked write, or a registered read of the addressed word.
      always_ff @(posedge clk_i) begin
        if (!csb0) begin
          if (!web0) begin
            for (int k = 0; k < 4; k++) begin
              if (wmask0[k]) mem[d_word][8*k +: 8] <= d_wdata_i[8*k +: 8];
            end
          end else begin
            dout0 <= mem[d_word];
          end
        end
      end

      // Macro port 1: read-only, registered output.
      always_ff @(posedge clk_i) begin
        if (!csb1) dout1 <= mem[i_word];
      end
    end
  endgenerate

  // Tracks one response per grant. The one-hot selects remember which bank is allowed to
  // drive read data next cycle. prio_i is the arbitration flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      illegal_q <= 1'b0;
      d_sel_q   <= '0;
      i_sel_q   <= '0;
      prio_i    <= 1'b0;
    end else begin
      d_valid_q <= d_gnt;
      d_err_q   <= d_gnt & ~d_legal;
      i_valid_q <= i_gnt;
      i_err_q   <= i_gnt & ~i_legal;
      illegal_q <= (d_gnt & ~d_legal) | (i_gnt & ~i_legal);
      d_sel_q   <= d_we_i ? '0 : d_hit;
      i_sel_q   <= i_hit;
      if (hazard && !prio_i) prio_i <= 1'b1;
      else if (i_gnt)        prio_i <= 1'b0;
    end
  end

  // Read data is the OR of the banks that were selected. Data is zero when no read is due.
  always_comb begin
    d_rd = '0;
    i_rd = '0;
    for (int n = 0; n < NUM_BANKS; n++) begin
      if (d_sel_q[n]) d_rd = d_rd | d_dout[n*32 +: 32];
      if (i_sel_q[n]) i_rd = i_rd | i_dout[n*32 +: 32];
    end
  end

`ifdef SRAM_BANK_CTRL_OUT_REG_EN
  logic        d_valid_r, d_err_r, i_valid_r, i_err_r, illegal_r;
  logic [31:0] d_rd_r, i_rd_r;

  // Extra output stage. It adds 1 cycle of latency and still accepts 1 response per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid_r <= 1'b0;
      d_err_r   <= 1'b0;
      d_rd_r    <= '0;
      i_valid_r <= 1'b0;
      i_err_r   <= 1'b0;
      i_rd_r    <= '0;
      illegal_r <= 1'b0;
    end else begin
      d_valid_r <= d_valid_q;
      d_err_r   <= d_err_q;
      d_rd_r    <= d_rd;
      i_valid_r <= i_valid_q;
      i_err_r   <= i_err_q;
      i_rd_r    <= i_rd;
      illegal_r <= illegal_q;
    end
  end

  assign d_rvalid_o       = d_valid_r;
  assign d_err_o          = d_err_r;
  assign d_rdata_o        = d_rd_r;
  assign i_rvalid_o       = i_valid_r;
  assign i_err_o          = i_err_r;
  assign i_rdata_o        = i_rd_r;
  assign illegal_memory_o = illegal_r;
`else
  assign d_rvalid_o       = d_valid_q;
  assign d_err_o          = d_err_q;
  assign d_rdata_o        = d_rd;
  assign i_rvalid_o       = i_valid_q;
  assign i_err_o          = i_err_q;
  assign i_rdata_o        = i_rd;
  assign illegal_memory_o = illegal_q;
`endif

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: directed scenarios and randomized traffic for sram_bank_ctrl, checked
// against a word-addressed memory model and a fixed-latency response pipeline.
module tb_sram_bank_ctrl;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          NB       = 24;
  // 24 banks of 512 words x 4 bytes = 0xC000 bytes, so the window ends at 0x8000_C000.
  localparam logic [32:0] END_ADDR = {1'b0, BASE} + 33'(NB * 2048);
`ifdef SRAM_BANK_CTRL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic        e;
    logic        known;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_i, d_req_i, d_we_i, i_req_i, i_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i, i_addr_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o, i_gnt_o, i_rvalid_o, i_err_o, illegal_memory_o;
  logic [31:0] d_rdata_o, i_rdata_o;

  int          errors = 0;
  int          checks = 0;
  bit          prio = 1'b0;
  logic [31:0] mem [int unsigned];
  resp_t       dpipe [2];
  resp_t       ipipe [2];
  logic [31:0] pool [10];

  always #5 clk = ~clk;

  sram_bank_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i), .i_we_i(i_we_i),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .illegal_memory_o(illegal_memory_o)
  );

  function automatic bit inWindow(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < END_ADDR);
  endfunction

  function automatic int unsigned wordOf(input logic [31:0] addr);
    return (addr - BASE) >> 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One bus cycle: drive the inputs, check the grants, advance the model at the clock edge,
  // then check the responses that the DUT presents after that edge.
  task automatic applyStimulus(input bit rst, input bit dreq, input bit dwe, input logic [3:0] dbe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input bit ireq, input bit iwe, input logic [31:0] iaddr);
    bit          dleg, ileg, hz, edg, eig;
    int unsigned dw, iw;
    resp_t       nd, ni, xd, xi;
    logic [31:0] merged;

    rst_i = rst; d_req_i = dreq; d_we_i = dwe; d_be_i = dbe; d_addr_i = daddr;
    d_wdata_i = dwdata; i_req_i = ireq; i_we_i = iwe; i_addr_i = iaddr;
    #1;
    dleg = inWindow(daddr);
    ileg = inWindow(iaddr) && !iwe;
    dw   = wordOf(daddr);
    iw   = wordOf(iaddr);
    hz   = dreq && dwe && dleg && ireq && ileg && (dw == iw);
    edg  = !rst && dreq && !(hz && prio);
    eig  = !rst && ireq && !(hz && !prio);
    checkOutput("d_gnt", {31'b0, d_gnt_o}, {31'b0, edg});
    checkOutput("i_gnt", {31'b0, i_gnt_o}, {31'b0, eig});

    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        dpipe[j] = '{v: 1'b0, e: 1'b0, known: 1'b1, data: 32'h0};
        ipipe[j] = '{v: 1'b0, e: 1'b0, known: 1'b1, data: 32'h0};
      end
      prio = 1'b0;
    end else begin
      nd = '{v: edg, e: edg && !dleg, known: 1'b1, data: 32'h0};
      if (edg && dleg && !dwe) begin
        nd.known = mem.exists(dw);
        if (nd.known) nd.data = mem[dw];
      end
      ni = '{v: eig, e: eig && !ileg, known: 1'b1, data: 32'h0};
      if (eig && ileg) begin
        ni.known = mem.exists(iw);
        if (ni.known) ni.data = mem[iw];
      end
      if (edg && dleg && dwe && (mem.exists(dw) || dbe == 4'hF)) begin
        merged = mem.exists(dw) ? mem[dw] : 32'h0;
        for (int k = 0; k < 4; k++) if (dbe[k]) merged[8*k +: 8] = dwdata[8*k +: 8];
        mem[dw] = merged;
      end
      if (hz && !prio) prio = 1'b1;
      else if (eig)    prio = 1'b0;
      dpipe[1] = dpipe[0]; dpipe[0] = nd;
      ipipe[1] = ipipe[0]; ipipe[0] = ni;
    end

    @(negedge clk);
    xd = dpipe[LAT-1];
    xi = ipipe[LAT-1];
    checkOutput("d_rvalid", {31'b0, d_rvalid_o}, {31'b0, xd.v});
    checkOutput("d_err", {31'b0, d_err_o}, {31'b0, xd.e});
    if (xd.known) checkOutput("d_rdata", d_rdata_o, xd.data);
    checkOutput("i_rvalid", {31'b0, i_rvalid_o}, {31'b0, xi.v});
    checkOutput("i_err", {31'b0, i_err_o}, {31'b0, xi.e});
    if (xi.known) checkOutput("i_rdata", i_rdata_o, xi.data);
    checkOutput("illegal_memory", {31'b0, illegal_memory_o}, {31'b0, xd.e | xi.e});
  endtask

  initial begin
    pool[0] = 32'h8000_0000; pool[1] = 32'h8000_0004; pool[2] = 32'h8000_0800;
    pool[3] = 32'h8000_0804; pool[4] = 32'h8000_1000; pool[5] = 32'h8000_BFFC;
    pool[6] = 32'h8000_05A0; pool[7] = 32'h8000_7000;
    pool[8] = END_ADDR[31:0]; pool[9] = 32'h7FFF_FFF0;

    // Reset, then one idle cycle.
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // A D write followed by an I read of the same word.
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_0204, 32'hDEAD_BEEF, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h8000_0204);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Partial write over all-ones, then read back.
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 4'h3, 32'h8000_0000, 32'h1234_5678, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_0000, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Three back-to-back cycles of a D write and an I read to the same word.
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_1000, 32'hCAFE_0001, 1, 0, 32'h8000_1000);
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_1000, 32'hCAFE_0002, 1, 0, 32'h8000_1000);
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_1000, 32'hCAFE_0003, 1, 0, 32'h8000_1000);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Window edges: the last legal word, END_ADDR, a far address, wrap-around, below BASE.
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_BFFC, 32'h1111_2222, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_BFFC, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, END_ADDR[31:0], 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h8001_8000, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h7FFF_FFFC, 32'h0, 1, 0, END_ADDR[31:0]);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // An I-port write is refused and does not change the stored word.
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_0010, 32'h0BAD_F00D, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h8000_0010);
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_0010, 32'h0, 0, 0, 32'h0);

    // A write with no byte enables, then a read of the unchanged word.
    applyStimulus(0, 1, 1, 4'h0, 32'h8000_0204, 32'h5555_5555, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_0204, 32'h0, 0, 0, 32'h0);

    // Two reads of the same word; a write and a read in the same bank; a write and a read in different banks.
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_0204, 32'h0, 1, 0, 32'h8000_0204);
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_0204, 32'h0102_0304, 1, 0, 32'h8000_0000);
    applyStimulus(0, 1, 1, 4'hF, 32'h8000_1000, 32'h0A0B_0C0D, 1, 0, 32'h8000_0204);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Reset while reads are outstanding on both ports.
    applyStimulus(0, 1, 0, 4'h0, 32'h8000_0204, 32'h0, 1, 0, 32'h8000_0000);
    applyStimulus(1, 1, 0, 4'h0, 32'h8000_0204, 32'h0, 1, 0, 32'h8000_0000);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Fill the legal addresses in the pool, then run random traffic over the pool.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 4'hF, pool[i], $urandom, 0, 0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                    pool[$urandom_range(0, 9)], $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    pool[$urandom_range(0, 9)]);
    end
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
